// File: rtl/event_stretch_if.sv
// Event-stretcher signal bundle: event input toward the block, indicator and status back out.
interface event_stretch_if #(
  parameter int PEND_W = 4
);
  logic              Din;
  logic              Dout;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (output Din, input Dout, busy, pending, overflow);
  modport slave  (input Din, output Dout, busy, pending, overflow);
endinterface

// File: rtl/event_stretch.sv
// Stretches single-cycle events into ON_CYCLES-high / GAP_CYCLES-low LED bursts.
// Events that arrive mid-burst are queued in a saturating counter; losses set a sticky overflow flag.
module event_stretch #(
  parameter int ON_CYCLES  = 10,
  parameter int GAP_CYCLES = 5,
  parameter int PEND_W     = 4
) (
  input logic            clk,
  input logic            reset,
  event_stretch_if.slave bus
);
  localparam int TMAX = ((ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES) - 1;
  localparam int TW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]     GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [1:0]        state, nxt_state;
  logic [TW-1:0]     timer, nxt_timer;
  logic              dout_q, nxt_dout;
  logic [PEND_W-1:0] pending_q, nxt_pending;
  logic              overflow_q, nxt_overflow;
  logic              start_burst, inc, dec, pend_nz;

  assign pend_nz = (pending_q != '0);

  always_comb begin
    nxt_state   = IDLE;
    nxt_timer   = '0;
    nxt_dout    = 1'b0;
    start_burst = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Din || pend_nz) begin
          start_burst = 1'b1;
          nxt_state   = ON;
          nxt_timer   = ON_LOAD;
          nxt_dout    = 1'b1;
        end
      end
      ON: begin
        if (timer == '0) begin
          nxt_state = GAP;
          nxt_timer = GAP_LOAD;
        end else begin
          nxt_state = ON;
          nxt_timer = timer - TW'(1);
          nxt_dout  = 1'b1;
        end
      end
      GAP: begin
        if (timer != '0) begin
          nxt_state = GAP;
          nxt_timer = timer - TW'(1);
        end else if (pend_nz) begin
          start_burst = 1'b1;
          nxt_state   = ON;
          nxt_timer   = ON_LOAD;
          nxt_dout    = 1'b1;
        end
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  // The event that opens a burst from an empty IDLE is shown directly, never queued.
  assign inc = bus.Din && !((state == IDLE) && !pend_nz);
  assign dec = start_burst && pend_nz;

  always_comb begin
    nxt_pending  = pending_q;
    nxt_overflow = overflow_q;
    if (inc && !dec) begin
      if (pending_q == PEND_MAX) begin
        nxt_overflow = 1'b1;
      end else begin
        nxt_pending = pending_q + PEND_W'(1);
      end
    end else if (dec && !inc) begin
      nxt_pending = pending_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= '0;
      dout_q     <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state      <= nxt_state;
      timer      <= nxt_timer;
      dout_q     <= nxt_dout;
      pending_q  <= nxt_pending;
      overflow_q <= nxt_overflow;
    end
  end

  assign bus.Dout     = dout_q;
  assign bus.busy     = (state != IDLE);
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;
endmodule
